pwm_wavegen: RTL and testbench

Multi-channel direct-digital-synthesis tone generator with a single PWM audio output, the parametrised successor to the single-channel sine PWM generator. Each of `N_CH` channels runs a `PHASE_W`-bit phase accumulator, shapes the phase into one of four waveforms with per-channel attenuation, and the channels are averaged into one 8-bit sample. That sample drives a 255-clock PWM frame. It sits between the top-level pin wrapper, which supplies the per-channel configuration buses, and the single audio pin.

---
 rtl/wavegen_pkg.sv | 41 ++++
 rtl/wavegen_osc.sv | 65 ++++++
 rtl/pwm_wavegen.sv | 94 +++++++++
 tb/tb_pwm_wavegen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wavegen_pkg.sv
// Shared constants, waveform encoding and the quarter-wave sine table for the
// multi-channel DDS tone generator.
package wavegen_pkg;

    localparam int         SAMPLE_W  = 8;
    localparam logic [7:0] FRAME_MAX = 8'd254;
    localparam logic [7:0] MIDSCALE  = 8'd128;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_SAW    = 2'd2,
        WAVE_TRI    = 2'd3
    } wave_e;

    // round(127 * sin(2*pi*k/256)) for k = 0..63, i.e. the first quadrant.
    localparam logic [6:0] SINE_Q [64] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
    };

    function automatic logic [6:0] sine_rom(input logic [5:0] idx);
        return SINE_Q[idx];
    endfunction

    // Quadrants 1 and 3 read the table backwards; quadrants 2 and 3 sit below midscale.
    function automatic logic [7:0] sine_lookup(input logic [7:0] p);
        logic [5:0] idx;
        logic [6:0] mag;
        idx = p[6] ? ~p[5:0] : p[5:0];
        mag = sine_rom(idx);
        return p[7] ? (MIDSCALE - {1'b0, mag}) : (MIDSCALE + {1'b0, mag});
    endfunction

endpackage

// File: rtl/wavegen_osc.sv
// One DDS channel: phase accumulator, waveform shaper and attenuator. Channel
// configuration is captured together with the phase step at each frame boundary.
module wavegen_osc
    import wavegen_pkg::*;
#(
    parameter int PHASE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                update,
    input  logic                en,
    input  logic [PHASE_W-1:0]  inc,
    input  logic [1:0]          wave,
    input  logic [1:0]          att,
    output logic [SAMPLE_W-1:0] level
);

    logic [PHASE_W-1:0] phase;
    logic               en_r;
    wave_e              wave_r;
    logic [1:0]         att_r;

    logic [7:0]         p;
    logic [7:0]         w;
    logic signed [8:0]  d;
    logic signed [8:0]  ds;
    logic signed [8:0]  v9;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= '0;
            en_r   <= 1'b0;
            wave_r <= WAVE_SINE;
            att_r  <= 2'd0;
        end else if (update) begin
            en_r   <= en;
            wave_r <= wave_e'(wave);
            att_r  <= att;
            phase  <= en ? (phase + inc) : '0;
        end
    end

    assign p = phase[PHASE_W-1 -: 8];

    always_comb begin
        w = p;
        case (wave_r)
            WAVE_SINE:   w = sine_lookup(p);
            WAVE_SQUARE: w = p[7] ? 8'd0 : 8'd255;
            WAVE_SAW:    w = p;
            WAVE_TRI:    w = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            default:     w = p;
        endcase
    end

    // Attenuate around midscale so a quiet channel still centres on 128.
    always_comb begin
        d  = $signed({1'b0, w} - 9'd128);
        ds = d >>> att_r;
        v9 = ds + 9'sd128;
    end

    assign level = en_r ? SAMPLE_W'(v9) : MIDSCALE;

endmodule

// File: rtl/pwm_wavegen.sv
// Multi-channel DDS tone generator: averages N_CH oscillators into one 8-bit
// sample and plays it as a 255-clock PWM frame with double-buffered duty.
module pwm_wavegen
    import wavegen_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int PHASE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         ch_en,
    input  logic [N_CH*PHASE_W-1:0] ch_inc,
    input  logic [N_CH*2-1:0]       ch_wave,
    input  logic [N_CH*2-1:0]       ch_att,
    output logic                    pwm,
    output logic [SAMPLE_W-1:0]     sample,
    output logic                    sample_stb
);

    localparam int SHIFT = $clog2(N_CH);
    localparam int SUM_W = SAMPLE_W + SHIFT;

    if (!(N_CH == 1 || N_CH == 2 || N_CH == 4 || N_CH == 8)) begin : g_bad_nch
        $fatal(1, "pwm_wavegen: N_CH must be 1, 2, 4 or 8");
    end
    if (PHASE_W < 8 || PHASE_W > 24) begin : g_bad_phase_w
        $fatal(1, "pwm_wavegen: PHASE_W must be in 8..24");
    end

    logic [7:0]          cnt;
    logic                update;
    logic [SAMPLE_W-1:0] levels [N_CH];
    logic [SUM_W-1:0]    sum;
    logic [SAMPLE_W-1:0] mix;
    logic [SAMPLE_W-1:0] sample_r;
    logic [SAMPLE_W-1:0] duty;

    assign update     = (cnt == FRAME_MAX);
    assign sample_stb = update && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else begin
            cnt <= update ? 8'd0 : cnt + 8'd1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        wavegen_osc #(
            .PHASE_W (PHASE_W)
        ) u_osc (
            .clk    (clk),
            .rst    (rst),
            .update (update),
            .en     (ch_en[i]),
            .inc    (ch_inc[i*PHASE_W +: PHASE_W]),
            .wave   (ch_wave[i*2 +: 2]),
            .att    (ch_att[i*2 +: 2]),
            .level  (levels[i])
        );
    end

    // Power-of-two channel count makes the average a plain right shift.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum = sum + SUM_W'(levels[i]);
        end
    end

    assign mix = SAMPLE_W'(sum >> SHIFT);

    // Mix is captured at the start of a frame, once the new phases have settled,
    // and handed to the comparator only at the next frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_r <= MIDSCALE;
            duty     <= MIDSCALE;
            pwm      <= 1'b0;
        end else begin
            if (cnt == 8'd0) begin
                sample_r <= mix;
            end
            if (update) begin
                duty <= sample_r;
            end
            pwm <= (cnt < duty);
        end
    end

    assign sample = duty;

endmodule

// File: tb/tb_pwm_wavegen.sv
// Directed bench for pwm_wavegen: a single-channel and a two-channel instance
// share clock and reset and are checked frame by frame against hand values.
module tb_pwm_wavegen;

    localparam real PI = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst;

    logic [0:0]  en1;
    logic [15:0] inc1;
    logic [1:0]  wave1;
    logic [1:0]  att1;
    logic        pwm1;
    logic [7:0]  sample1;
    logic        stb1;

    logic [1:0]  en2;
    logic [31:0] inc2;
    logic [3:0]  wave2;
    logic [3:0]  att2;
    logic        pwm2;
    logic [7:0]  sample2;
    logic        stb2;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    pwm_wavegen #(.N_CH(1), .PHASE_W(16)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .ch_en      (en1),
        .ch_inc     (inc1),
        .ch_wave    (wave1),
        .ch_att     (att1),
        .pwm        (pwm1),
        .sample     (sample1),
        .sample_stb (stb1)
    );

    pwm_wavegen #(.N_CH(2), .PHASE_W(16)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .ch_en      (en2),
        .ch_inc     (inc2),
        .ch_wave    (wave2),
        .ch_att     (att2),
        .pwm        (pwm2),
        .sample     (sample2),
        .sample_stb (stb2)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int expv);
        checks++;
        assert ((obs + 1 >= expv) && (obs <= expv + 1)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (+/-1)", tag, obs, expv);
        end
    endtask

    function automatic int sine_ref(input int p);
        int q;
        int j;
        int idx;
        int mag;
        q   = p / 64;
        j   = p % 64;
        idx = (q % 2 == 1) ? 63 - j : j;
        mag = $rtoi(127.0 * $sin(2.0 * PI * real'(idx) / 256.0) + 0.5);
        return (q < 2) ? 128 + mag : 128 - mag;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pwm1", 16'(pwm1), 16'd0);
        check("rst_pwm2", 16'(pwm2), 16'd0);
        check("rst_stb1", 16'(stb1), 16'd0);
        check("rst_sample1", 16'(sample1), 16'd128);
        check("rst_sample2", 16'(sample2), 16'd128);
        rst = 1'b0;
    endtask

    // Walks the first post-reset frame: 128 highs, 127 lows, strobe on cnt 254.
    task automatic check_first_frame();
        for (int j = 1; j <= 255; j++) begin
            @(negedge clk);
            check("frame0_pwm1", 16'(pwm1), 16'(j <= 128));
            check("frame0_pwm2", 16'(pwm2), 16'(j <= 128));
            check("frame0_stb1", 16'(stb1), 16'(j == 254));
            check("frame0_stb2", 16'(stb2), 16'(j == 254));
            if (j == 1 || j == 255) begin
                check("frame0_sample1", 16'(sample1), 16'd128);
                check("frame0_sample2", 16'(sample2), 16'd128);
            end
        end
    endtask

    // Leaves the caller on cnt==0 of the next frame.
    task automatic next_frame();
        int n;
        n = 0;
        while (stb1 !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (stb1 !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: observed no strobe in %0d cycles, expected within 255", n);
        end
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst   = 1'b1;
        en1   = 1'b1;
        inc1  = 16'h8000;
        wave1 = 2'd1;
        att1  = 2'd0;
        en2   = 2'b11;
        inc2  = {16'h8000, 16'h0000};
        wave2 = {2'd1, 2'd0};
        att2  = {2'd1, 2'd0};

        do_reset();
        check_first_frame();

        // Square on dut1 (0/255); dut2 mixes held 128 with attenuated square (96/159).
        for (int f = 2; f <= 7; f++) begin
            next_frame();
            check("square_sample", 16'(sample1), (f % 2 == 1) ? 16'd255 : 16'd0);
            check("mix_sample", 16'(sample2), (f % 2 == 1) ? 16'd159 : 16'd96);
            repeat (10) @(negedge clk);
            check("square_pwm", 16'(pwm1), 16'(f % 2 == 1));
            check("mix_pwm", 16'(pwm2), 16'd1);
        end

        // Frame 7 plays duty 255; abort it at cnt 100 and load the next scenario.
        repeat (90) @(negedge clk);
        check("pre_reset_pwm", 16'(pwm1), 16'd1);
        rst   = 1'b1;
        en1   = 1'b1;
        inc1  = 16'h0100;
        wave1 = 2'd0;
        att1  = 2'd0;
        en2   = 2'b10;
        inc2  = {16'hFFFF, 16'h0000};
        wave2 = {2'd2, 2'd0};
        att2  = {2'd0, 2'd0};
        @(negedge clk);
        check("midreset_pwm", 16'(pwm1), 16'd0);
        check("midreset_duty", 16'(sample1), 16'd128);
        rst = 1'b0;
        check_first_frame();

        for (int f = 2; f <= 257; f++) begin
            exp_q.push_back(8'(sine_ref((f - 1) % 256)));
        end

        // Sine sweeps p by one per frame; dut2 saw wraps then is disabled mid-frame 4.
        for (int f = 2; f <= 257; f++) begin
            int p;
            logic [7:0] e;
            next_frame();
            p = (f - 1) % 256;
            e = exp_q.pop_front();
            check_near("sine_sample", int'(sample1), int'(e));
            if (p == 64)  check("sine_peak", 16'(sample1), 16'd255);
            if (p == 192) check("sine_min", 16'(sample1), 16'd1);
            if (p == 0)   check("sine_zero", 16'(sample1), 16'd128);
            if (p == 128) check("sine_half", 16'(sample1), 16'd128);
            check("wrap_disable", 16'(sample2), (f <= 5) ? 16'd191 : 16'd128);
            if (f == 4) begin
                repeat (100) @(negedge clk);
                en2 = 2'b00;
                repeat (5) @(negedge clk);
                check("disable_midframe", 16'(sample2), 16'd191);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
